// File: rtl/alarm_ringer.sv
// alarm_ringer: alarm clock ringer controller (IDLE / RINGING / SNOOZE).
//
// Parameters:
//   RING_SECONDS   - ring duration in tick_1hz pulses before timeout
//   SNOOZE_SECONDS - snooze interval in tick_1hz pulses
//   MAX_SNOOZES    - snoozes allowed per alarm event (1..3)
//   TONE_DIV       - clk cycles per buzzer half-period
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - asynchronous active-low reset
//   tick_1hz      - one-clk pulse per second
//   alarm_trigger - level, high while current time equals alarm time
//   alarm_enable  - level, alarm armed when high (dropping it aborts any event)
//   stop_btn      - one-clk pulse
//   snooze_btn    - one-clk pulse
//   buzzer        - tone square wave, active only while ringing
//   ringing       - high in RINGING
//   snoozing      - high in SNOOZE
//   snooze_count  - snoozes used in the current (or last) event
//
// Optional feature: define ALARM_AUTO_SNOOZE_EN to turn a ring timeout into an
// automatic snooze while snoozes remain.

module alarm_ringer #(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_SECONDS = 300,
  parameter int unsigned MAX_SNOOZES    = 3,
  parameter int unsigned TONE_DIV       = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       alarm_trigger,
  input  logic       alarm_enable,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_count
);

  // One shared seconds counter, sized for the longer of the two intervals.
  localparam int unsigned SecMax = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS
                                                                   : SNOOZE_SECONDS;
  localparam int unsigned SecW   = $clog2(SecMax + 1);
  localparam int unsigned ToneW  = $clog2(TONE_DIV + 1);

  typedef enum logic [1:0] {StIdle, StRinging, StSnooze} state_e;

  state_e            state_q, state_d;
  logic [SecW-1:0]   sec_q, sec_d, sec_inc;
  logic [ToneW-1:0]  tone_q, tone_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              buzzer_q, buzzer_d;
  logic              ringing_q, snoozing_q;
  logic              trig_q;
  logic              rise, ring_done, snooze_done, can_snooze;

  assign rise        = alarm_trigger & ~trig_q;
  assign sec_inc     = sec_q + SecW'(1);
  assign ring_done   = tick_1hz && (sec_inc == SecW'(RING_SECONDS));
  assign snooze_done = tick_1hz && (sec_inc == SecW'(SNOOZE_SECONDS));
  assign can_snooze  = cnt_q < 2'(MAX_SNOOZES);

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    cnt_d    = cnt_q;
    tone_d   = '0;
    buzzer_d = 1'b0;

    if (!alarm_enable) begin
      state_d = StIdle;
      sec_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_d = StRinging;
            sec_d   = '0;
            cnt_d   = '0;
          end
        end
        StRinging: begin
          // Tone generator runs only while staying in RINGING.
          if (tone_q == ToneW'(TONE_DIV - 1)) begin
            tone_d   = '0;
            buzzer_d = ~buzzer_q;
          end else begin
            tone_d   = tone_q + ToneW'(1);
            buzzer_d = buzzer_q;
          end
          if (tick_1hz) sec_d = sec_inc;

          if (stop_btn || (snooze_btn && !can_snooze)) begin
            state_d = StIdle;
          end else if (snooze_btn) begin
            state_d = StSnooze;
            cnt_d   = cnt_q + 2'd1;
          end else if (ring_done) begin
`ifdef ALARM_AUTO_SNOOZE_EN
            if (can_snooze) begin
              state_d = StSnooze;
              cnt_d   = cnt_q + 2'd1;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end

          if (state_d != StRinging) begin
            sec_d    = '0;
            tone_d   = '0;
            buzzer_d = 1'b0;
          end
        end
        StSnooze: begin
          if (tick_1hz) sec_d = sec_inc;
          if (stop_btn) begin
            state_d = StIdle;
            sec_d   = '0;
          end else if (snooze_done) begin
            state_d = StRinging;
            sec_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          sec_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sec_q      <= '0;
      tone_q     <= '0;
      cnt_q      <= '0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      // Reset high so a trigger already high at release cannot start a ring.
      trig_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      tone_q     <= tone_d;
      cnt_q      <= cnt_d;
      buzzer_q   <= buzzer_d;
      ringing_q  <= (state_d == StRinging);
      snoozing_q <= (state_d == StSnooze);
      trig_q     <= alarm_trigger;
    end
  end

  assign buzzer       = buzzer_q;
  assign ringing      = ringing_q;
  assign snoozing     = snoozing_q;
  assign snooze_count = cnt_q;

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;

  logic       clk, rst, tick_1hz, alarm_trigger, alarm_enable, stop_btn, snooze_btn;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_count;

  int n_cmp = 0;
  int n_err = 0;

  alarm_ringer #(
    .RING_SECONDS  (4),
    .SNOOZE_SECONDS(2),
    .MAX_SNOOZES   (3),
    .TONE_DIV      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .alarm_trigger(alarm_trigger),
    .alarm_enable (alarm_enable),
    .stop_btn     (stop_btn),
    .snooze_btn   (snooze_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_count (snooze_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_pulse();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    cyc(1);
  endtask

  task automatic snooze_pulse();
    snooze_btn = 1'b1;
    cyc(1);
    snooze_btn = 1'b0;
  endtask

  task automatic start_ring();
    alarm_trigger = 1'b1;
    cyc(1);
    alarm_trigger = 1'b0;
  endtask

  initial begin
    rst = 1'b0; tick_1hz = 1'b0; alarm_trigger = 1'b0; alarm_enable = 1'b1;
    stop_btn = 1'b0; snooze_btn = 1'b0;
    #2;
    chk("reset_ringing", ringing, 0);
    chk("reset_snoozing", snoozing, 0);
    chk("reset_buzzer", buzzer, 0);
    chk("reset_count", snooze_count, 0);
    cyc(2);
    rst = 1'b1;
    cyc(2);

    // Ring, tone pattern, timeout after the 4th tick.
    alarm_trigger = 1'b1;
    cyc(1);
    chk("ring_start", ringing, 1);
    chk("buzz_0", buzzer, 0);
    cyc(1); chk("buzz_1", buzzer, 0);
    cyc(1); chk("buzz_2", buzzer, 1);
    cyc(1); chk("buzz_3", buzzer, 1);
    cyc(1); chk("buzz_4", buzzer, 0);
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      chk("ring_before_timeout", ringing, 1);
    end
    tick_pulse();
    chk("timeout_ringing", ringing, 0);
`ifdef ALARM_AUTO_SNOOZE_EN
    chk("timeout_auto_snooze", snoozing, 1);
    chk("timeout_auto_count", snooze_count, 1);
`else
    chk("timeout_snoozing", snoozing, 0);
    chk("timeout_buzzer", buzzer, 0);
`endif
    alarm_enable = 1'b0;
    cyc(1);
    alarm_enable = 1'b1;
    cyc(3);
    chk("held_trigger_no_retrigger", ringing, 0);
    alarm_trigger = 1'b0;
    cyc(1);

    // Three snoozes with re-ring, fourth snooze acts as stop.
    start_ring();
    chk("snz_ring", ringing, 1);
    for (int k = 1; k <= 3; k++) begin
      snooze_pulse();
      chk("snz_snoozing", snoozing, 1);
      chk("snz_count", snooze_count, 32'(k));
      chk("snz_buzzer", buzzer, 0);
      tick_pulse();
      chk("snz_after_1tick", snoozing, 1);
      tick_pulse();
      chk("snz_rering", ringing, 1);
    end
    snooze_pulse();
    chk("snz4_ringing", ringing, 0);
    chk("snz4_snoozing", snoozing, 0);
    chk("snz4_count_hold", snooze_count, 3);

    // Stop and snooze together: stop wins, count unchanged.
    start_ring();
    chk("new_event_count_clr", snooze_count, 0);
    snooze_pulse();
    tick_pulse();
    tick_pulse();
    chk("both_pre_ring", ringing, 1);
    stop_btn = 1'b1; snooze_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0; snooze_btn = 1'b0;
    chk("both_ringing", ringing, 0);
    chk("both_snoozing", snoozing, 0);
    chk("both_count", snooze_count, 1);

    // Snooze ignored in SNOOZE; stop in SNOOZE returns to idle.
    start_ring();
    snooze_pulse();
    snooze_pulse();
    chk("snz_in_snz_count", snooze_count, 1);
    chk("snz_in_snz_state", snoozing, 1);
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
    chk("stop_in_snz", snoozing, 0);

    // Async reset mid-ring with trigger held high.
    alarm_trigger = 1'b1;
    cyc(3);
    chk("rst_pre_ring", ringing, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_ringing", ringing, 0);
    chk("rst_async_buzzer", buzzer, 0);
    #2 rst = 1'b1;
    cyc(3);
    chk("rst_no_ring_after", ringing, 0);
    alarm_trigger = 1'b0;
    cyc(1);

    // Enable drop during SNOOZE aborts, no re-ring.
    start_ring();
    snooze_pulse();
    alarm_enable = 1'b0;
    cyc(1);
    alarm_enable = 1'b1;
    chk("en_drop_snoozing", snoozing, 0);
    tick_pulse(); tick_pulse(); tick_pulse();
    chk("en_drop_no_rering", ringing, 0);

    // Rising edge with enable low is ignored.
    alarm_enable = 1'b0;
    start_ring();
    chk("disabled_no_ring", ringing, 0);
    alarm_enable = 1'b1;
    cyc(1);

    // Snooze wins over simultaneous timeout.
    start_ring();
    tick_pulse(); tick_pulse(); tick_pulse();
    tick_1hz = 1'b1; snooze_btn = 1'b1;
    cyc(1);
    tick_1hz = 1'b0; snooze_btn = 1'b0;
    chk("snz_over_timeout_state", snoozing, 1);
    chk("snz_over_timeout_count", snooze_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
